// File: rtl/router_ingress_ctrl_if.sv
// Ingress-side bundle of the packet router: source byte stream with its
// back-pressure, the per-channel FIFO strobes and the error/status outputs.
// master = source and FIFO side, slave = ingress controller.
interface router_ingress_ctrl_if;
   logic [7:0] data;
   logic       packet_valid;
   logic [2:0] fifo_full;
   logic       suspend_data_in;
   logic [2:0] fifo_wr_en;
   logic [7:0] fifo_wr_data;
   logic       err;
   logic [1:0] err_code;
   logic       busy;

   modport master (
      output data, packet_valid, fifo_full,
      input  suspend_data_in, fifo_wr_en, fifo_wr_data, err, err_code, busy
   );

   modport slave (
      input  data, packet_valid, fifo_full,
      output suspend_data_in, fifo_wr_en, fifo_wr_data, err, err_code, busy
   );
endinterface

// File: rtl/router_ingress_ctrl.sv
// Ingress controller for the 3-channel packet router. Parses
// header / payload / parity framing, steers accepted bytes to the selected
// channel FIFO, back-pressures the source and reports parity, address and
// truncation errors as one-cycle pulses.
module router_ingress_ctrl #(
   parameter bit PARITY_EN     = 1'b1,
   parameter bit DROP_BAD_ADDR = 1'b1
) (
   input logic                  clock,
   input logic                  reset,
   router_ingress_ctrl_if.slave bus
);

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_PAYLOAD = 2'd1;
   localparam logic [1:0] ST_PARITY  = 2'd2;
   localparam logic [1:0] ST_DROP    = 2'd3;

   logic [1:0] state;
   logic [1:0] dest;
   logic [5:0] remaining;
   logic [7:0] par;

   logic [2:0] wr_en_q;
   logic [7:0] wr_data_q;
   logic       err_q;
   logic [1:0] err_code_q;

   logic [1:0] hdr_addr;
   logic [5:0] hdr_len;
   logic       hdr_bad;
   logic [1:0] hdr_dest;
   logic [3:0] full_ext;
   logic       suspend;
   logic       accept;

   assign hdr_addr = bus.data[1:0];
   assign hdr_len  = bus.data[7:2];
   assign hdr_bad  = (hdr_addr == 2'd3);
   assign hdr_dest = hdr_bad ? 2'd0 : hdr_addr;
   // Padded so a 2-bit address indexes it without running off the end;
   // the fourth slot is never full.
   assign full_ext = {1'b0, bus.fifo_full};

   // Back-pressure: header waits on its target FIFO, payload/parity on the
   // latched channel; a dropped packet is always drained.
   always_comb begin
      suspend = 1'b0;
      case (state)
         ST_IDLE:               suspend = bus.packet_valid && !hdr_bad && full_ext[hdr_addr];
         ST_PAYLOAD, ST_PARITY: suspend = full_ext[dest];
         default:               suspend = 1'b0;
      endcase
   end

   assign accept = bus.packet_valid && !suspend;

   // Packet framing FSM with registered FIFO strobe and error pulse.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state      <= ST_IDLE;
         dest       <= '0;
         remaining  <= '0;
         par        <= '0;
         wr_en_q    <= '0;
         wr_data_q  <= '0;
         err_q      <= 1'b0;
         err_code_q <= '0;
      end else begin
         wr_en_q <= '0;
         err_q   <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  if (hdr_bad && DROP_BAD_ADDR) begin
                     err_q      <= 1'b1;
                     err_code_q <= 2'b10;
                     state      <= ST_DROP;
                  end else begin
                     dest      <= hdr_dest;
                     remaining <= hdr_len;
                     par       <= bus.data;
                     wr_en_q   <= 3'b001 << hdr_dest;
                     wr_data_q <= bus.data;
                     state     <= (hdr_len != 6'd0) ? ST_PAYLOAD : ST_PARITY;
                  end
               end
            end
            ST_PAYLOAD: begin
               if (!bus.packet_valid) begin
                  err_q      <= 1'b1;
                  err_code_q <= 2'b11;
                  state      <= ST_IDLE;
               end else if (accept) begin
                  wr_en_q   <= 3'b001 << dest;
                  wr_data_q <= bus.data;
                  par       <= par ^ bus.data;
                  remaining <= remaining - 6'd1;
                  if (remaining == 6'd1) begin
                     state <= ST_PARITY;
                  end
               end
            end
            ST_PARITY: begin
               if (!bus.packet_valid) begin
                  err_q      <= 1'b1;
                  err_code_q <= 2'b11;
                  state      <= ST_IDLE;
               end else if (accept) begin
                  wr_en_q   <= 3'b001 << dest;
                  wr_data_q <= bus.data;
                  if (PARITY_EN && (bus.data != par)) begin
                     err_q      <= 1'b1;
                     err_code_q <= 2'b01;
                  end
                  state <= ST_IDLE;
               end
            end
            ST_DROP: begin
               if (!bus.packet_valid) begin
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign bus.suspend_data_in = suspend;
   assign bus.fifo_wr_en      = wr_en_q;
   assign bus.fifo_wr_data    = wr_data_q;
   assign bus.err             = err_q;
   assign bus.err_code        = err_code_q;
   assign bus.busy            = (state != ST_IDLE);

endmodule
